// File: rtl/sseg_scan_rx_if.sv
// Observed 7-segment scan bus plus the receiver's captured results.
// Hex-decode signals exist only when SSEG_SCAN_RX_HEX_EN is defined.
interface sseg_scan_rx_if;
   logic [3:0] an_in;
   logic [7:0] sseg_in;
   logic [7:0] led0;
   logic [7:0] led1;
   logic [7:0] led2;
   logic [7:0] led3;
   logic       frame_valid;
   logic       frame_tick;
   logic       an_err;
   logic       seq_err;
`ifdef SSEG_SCAN_RX_HEX_EN
   logic [3:0] hex0;
   logic [3:0] hex1;
   logic [3:0] hex2;
   logic [3:0] hex3;
   logic [3:0] hex_ok;

   modport master (
      output an_in, sseg_in,
      input  led0, led1, led2, led3, frame_valid, frame_tick, an_err, seq_err,
      input  hex0, hex1, hex2, hex3, hex_ok
   );
   modport slave (
      input  an_in, sseg_in,
      output led0, led1, led2, led3, frame_valid, frame_tick, an_err, seq_err,
      output hex0, hex1, hex2, hex3, hex_ok
   );
`else
   modport master (
      output an_in, sseg_in,
      input  led0, led1, led2, led3, frame_valid, frame_tick, an_err, seq_err
   );
   modport slave (
      input  an_in, sseg_in,
      output led0, led1, led2, led3, frame_valid, frame_tick, an_err, seq_err
   );
`endif
endinterface

// File: rtl/sseg_scan_rx.sv
// Rebuilds four digit patterns from an observed multiplexed 7-segment scan and checks order.
// Defining SSEG_SCAN_RX_HEX_EN adds registered hex decode of each captured digit.
module sseg_scan_rx #(
   parameter int unsigned STABLE_CNT = 4,
   parameter int unsigned TIMEOUT    = 1048576
) (
   input  logic          clk,
   input  logic          reset,
   sseg_scan_rx_if.slave bus
);
   // STABLE_CNT held cycles means STABLE_CNT-1 repeated samples after the change.
   localparam logic [7:0]  STAB_LAST = 8'(STABLE_CNT - 1);
   localparam logic [24:0] TO_MAX    = 25'(TIMEOUT);

   typedef enum logic [2:0] {StHunt, StExp0, StExp1, StExp2, StExp3} state_e;

   logic [11:0]     r_meta, r_sync, r_prev;
   logic [7:0]      r_stab;
   logic [24:0]     r_idle;
   logic [3:0][7:0] r_led;
   logic            r_frame_valid, r_frame_tick, r_an_err, r_seq_err;
   state_e          r_state, w_state_d, w_next;

   logic       w_same, w_cap, w_valid, w_bad, w_cap_digit, w_cap_bad, w_timeout;
   logic       w_tick, w_seq;
   logic [1:0] w_digit, w_exp;

   assign w_same      = (r_sync == r_prev);
   assign w_cap       = w_same && (r_stab == STAB_LAST - 8'd1);
   assign w_cap_digit = w_cap && w_valid;
   assign w_cap_bad   = w_cap && w_bad;
   assign w_timeout   = !w_cap_digit && (r_idle == TO_MAX - 25'd1);

   always_comb begin
      w_digit = 2'd0;
      w_valid = 1'b0;
      w_bad   = 1'b0;
      case (r_sync[11:8])
         4'b1110: begin w_valid = 1'b1; w_digit = 2'd0; end
         4'b1101: begin w_valid = 1'b1; w_digit = 2'd1; end
         4'b1011: begin w_valid = 1'b1; w_digit = 2'd2; end
         4'b0111: begin w_valid = 1'b1; w_digit = 2'd3; end
         4'b1111: ;
         default: w_bad = 1'b1;
      endcase
   end

   always_comb begin
      case (r_state)
         StExp1:  begin w_exp = 2'd1; w_next = StExp2; end
         StExp2:  begin w_exp = 2'd2; w_next = StExp3; end
         StExp3:  begin w_exp = 2'd3; w_next = StExp0; end
         default: begin w_exp = 2'd0; w_next = StExp1; end
      endcase
   end

   always_comb begin
      w_state_d = r_state;
      w_tick    = 1'b0;
      w_seq     = 1'b0;
      if (w_cap_bad || w_timeout) begin
         w_state_d = StHunt;
      end else if (w_cap_digit) begin
         if (r_state == StHunt) begin
            if (w_digit == 2'd0) w_state_d = StExp1;
         end else if (w_digit == w_exp) begin
            w_state_d = w_next;
            w_tick    = (w_exp == 2'd3);
         end else begin
            // A stray digit0 is most likely a new frame start, so keep collecting.
            w_seq     = 1'b1;
            w_state_d = (w_digit == 2'd0) ? StExp1 : StHunt;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_meta <= '1;
         r_sync <= '1;
         r_prev <= '1;
         r_stab <= '0;
      end else begin
         r_meta <= {bus.an_in, bus.sseg_in};
         r_sync <= r_meta;
         r_prev <= r_sync;
         if (!w_same) begin
            r_stab <= '0;
         end else if (r_stab != STAB_LAST) begin
            r_stab <= r_stab + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= StHunt;
         r_idle        <= '0;
         r_led         <= '1;
         r_frame_valid <= 1'b0;
         r_frame_tick  <= 1'b0;
         r_an_err      <= 1'b0;
         r_seq_err     <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_frame_tick <= w_tick;
         r_an_err     <= w_cap_bad;
         r_seq_err    <= w_seq;
         if (w_tick) begin
            r_frame_valid <= 1'b1;
         end else if (w_timeout) begin
            r_frame_valid <= 1'b0;
         end
         if (w_cap_digit) begin
            r_led[w_digit] <= r_sync[7:0];
            r_idle         <= '0;
         end else if (r_idle != TO_MAX) begin
            r_idle <= r_idle + 25'd1;
         end
      end
   end

   assign bus.led0        = r_led[0];
   assign bus.led1        = r_led[1];
   assign bus.led2        = r_led[2];
   assign bus.led3        = r_led[3];
   assign bus.frame_valid = r_frame_valid;
   assign bus.frame_tick  = r_frame_tick;
   assign bus.an_err      = r_an_err;
   assign bus.seq_err     = r_seq_err;

`ifdef SSEG_SCAN_RX_HEX_EN
   // {ok, value}; dp is ignored, unknown patterns decode to {0, 0}.
   function automatic logic [4:0] hex_decode(input logic [6:0] seg);
      logic [4:0] dec;
      dec = 5'd0;
      case (seg)
         7'h40: dec = 5'h10;
         7'h79: dec = 5'h11;
         7'h24: dec = 5'h12;
         7'h30: dec = 5'h13;
         7'h19: dec = 5'h14;
         7'h12: dec = 5'h15;
         7'h02: dec = 5'h16;
         7'h78: dec = 5'h17;
         7'h00: dec = 5'h18;
         7'h10: dec = 5'h19;
         7'h08: dec = 5'h1A;
         7'h03: dec = 5'h1B;
         7'h46: dec = 5'h1C;
         7'h21: dec = 5'h1D;
         7'h06: dec = 5'h1E;
         7'h0E: dec = 5'h1F;
         default: dec = 5'h00;
      endcase
      return dec;
   endfunction

   logic [3:0][3:0] r_hex;
   logic [3:0]      r_hex_ok;
   logic [4:0]      w_hex;

   assign w_hex = hex_decode(r_sync[6:0]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hex    <= '0;
         r_hex_ok <= '0;
      end else if (w_cap_digit) begin
         r_hex[w_digit]    <= w_hex[3:0];
         r_hex_ok[w_digit] <= w_hex[4];
      end
   end

   assign bus.hex0   = r_hex[0];
   assign bus.hex1   = r_hex[1];
   assign bus.hex2   = r_hex[2];
   assign bus.hex3   = r_hex[3];
   assign bus.hex_ok = r_hex_ok;
`endif
endmodule

// File: tb/tb_sseg_scan_rx.sv
// Directed plus randomized scan stimulus for sseg_scan_rx, checked against an
// event-level reference model (captures, digit order and timeout by arithmetic).
module tb_sseg_scan_rx;
   localparam int unsigned S  = 4;
   localparam int unsigned TO = 64;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   sseg_scan_rx_if bus ();

   sseg_scan_rx #(
      .STABLE_CNT(S),
      .TIMEOUT   (TO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Observed pulse counts and edge stamps.
   int   edges = 0;
   int   n_tick = 0, n_aerr = 0, n_serr = 0;
   int   tick_edge = 0, fall_edge = 0;
   logic fv_prev = 1'b0;

   always @(posedge clk) edges <= edges + 1;

   always @(negedge clk) begin
      if (bus.frame_tick) begin
         n_tick    <= n_tick + 1;
         tick_edge <= edges;
      end
      if (bus.an_err)  n_aerr <= n_aerr + 1;
      if (bus.seq_err) n_serr <= n_serr + 1;
      if (fv_prev && !bus.frame_valid) fall_edge <= edges;
      fv_prev <= bus.frame_valid;
   end

   // Reference model: m_state = -1 hunting, otherwise the digit expected next.
   logic [7:0]  m_led [4];
   logic        m_fv;
   int          m_state, m_tick, m_aerr, m_serr;
   int          now, last_valid;
   bit          to_done;
   logic [11:0] prev_val;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] digit_an(input int d);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << d);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_led[k] = 8'hFF;
      m_fv       = 1'b0;
      m_state    = -1;
      now        = 0;
      last_valid = 0;
      to_done    = 1'b0;
      prev_val   = 12'hFFF;
   endtask

   task automatic apply_timeout();
      m_fv    = 1'b0;
      m_state = -1;
      to_done = 1'b1;
   endtask

   // Capture of a stable (an, sg) whose register effect lands at edge c.
   task automatic model_capture(input logic [3:0] an, input logic [7:0] sg, input int c);
      int d;
      d = -2;
      for (int k = 0; k < 4; k++) if (an == digit_an(k)) d = k;
      if (an == 4'hF) return;
      if (d == -2) begin
         if (!to_done && last_valid + int'(TO) <= c) apply_timeout();
         m_aerr++;
         m_state = -1;
         return;
      end
      if (!to_done && last_valid + int'(TO) < c) apply_timeout();
      m_led[d]   = sg;
      last_valid = c;
      to_done    = 1'b0;
      if (m_state == -1) begin
         if (d == 0) m_state = 1;
      end else if (d == m_state) begin
         if (d == 3) begin
            m_tick++;
            m_fv    = 1'b1;
            m_state = 0;
         end else begin
            m_state = d + 1;
         end
      end else begin
         m_serr++;
         m_state = (d == 0) ? 1 : -1;
      end
   endtask

   // Hold (an, sg) for n cycles; a hold of at least S cycles is one capture.
   task automatic drive(input logic [3:0] an, input logic [7:0] sg, input int n);
      if ({an, sg} != prev_val && n >= int'(S)) model_capture(an, sg, now + int'(S) + 2);
      prev_val   = {an, sg};
      bus.an_in   = an;
      bus.sseg_in = sg;
      repeat (n) @(negedge clk);
      now += n;
   endtask

   task automatic check_state(input string tag);
      if (!to_done && last_valid + int'(TO) <= now) apply_timeout();
      chk({tag, "_led0"}, 32'(bus.led0), 32'(m_led[0]));
      chk({tag, "_led1"}, 32'(bus.led1), 32'(m_led[1]));
      chk({tag, "_led2"}, 32'(bus.led2), 32'(m_led[2]));
      chk({tag, "_led3"}, 32'(bus.led3), 32'(m_led[3]));
      chk({tag, "_fv"}, 32'(bus.frame_valid), 32'(m_fv));
      chk({tag, "_ticks"}, n_tick, m_tick);
      chk({tag, "_an_errs"}, n_aerr, m_aerr);
      chk({tag, "_seq_errs"}, n_serr, m_serr);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_led0"}, 32'(bus.led0), 32'hFF);
      chk({tag, "_led1"}, 32'(bus.led1), 32'hFF);
      chk({tag, "_led2"}, 32'(bus.led2), 32'hFF);
      chk({tag, "_led3"}, 32'(bus.led3), 32'hFF);
      chk({tag, "_fv"}, 32'(bus.frame_valid), 32'h0);
      chk({tag, "_tick"}, 32'(bus.frame_tick), 32'h0);
      chk({tag, "_an_err"}, 32'(bus.an_err), 32'h0);
      chk({tag, "_seq_err"}, 32'(bus.seq_err), 32'h0);
   endtask

   initial begin
      int          ld;
      int          serr0;
      int          r;
      int          n;
      logic [3:0]  an;
      logic [7:0]  sg;

      bus.an_in   = 4'hF;
      bus.sseg_in = 8'hFF;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b1;
      now   = 0;

      // Clean scan 0..3.
      drive(4'b1110, 8'hC0, 50);
      drive(4'b1101, 8'hF9, 50);
      drive(4'b1011, 8'hA4, 50);
      drive(4'b0111, 8'hB0, 50);
      check_state("clean");
      chk("clean_led0_const", 32'(bus.led0), 32'hC0);
      chk("clean_led3_const", 32'(bus.led3), 32'hB0);
      chk("clean_fv_const", 32'(bus.frame_valid), 32'h1);
      chk("clean_one_tick", n_tick, 1);
`ifdef SSEG_SCAN_RX_HEX_EN
      chk("hex0", 32'(bus.hex0), 32'h0);
      chk("hex1", 32'(bus.hex1), 32'h1);
      chk("hex2", 32'(bus.hex2), 32'h2);
      chk("hex3", 32'(bus.hex3), 32'h3);
      chk("hex_ok", 32'(bus.hex_ok), 32'hF);
`endif

      // Short digit1 glitch at the start of a digit0 hold.
      drive(4'b1110, 8'hC0, 2);
      drive(4'b1101, 8'hC0, 3);
      drive(4'b1110, 8'hC0, 45);
      check_state("glitch");
      chk("glitch_led1_kept", 32'(bus.led1), 32'hF9);
      chk("glitch_no_seq_err", n_serr, 0);

      // Digit2 straight after digit0.
      serr0 = n_serr;
      drive(4'b1011, 8'h92, 50);
      check_state("order");
      chk("order_seq_err", n_serr, serr0 + 1);
      chk("order_led2_written", 32'(bus.led2), 32'h92);
      drive(4'b0111, 8'h99, 50);
      check_state("order_hunt");
      chk("order_no_tick", n_tick, 1);

      // Illegal anode, then blanking.
      drive(4'b1100, 8'h00, 50);
      check_state("bad_an");
      chk("bad_an_pulse", n_aerr, 1);
      drive(4'b1111, 8'hFF, 50);
      check_state("blank");
      chk("blank_no_pulse", n_aerr, 1);

      // Frame then a long blank: frame_valid must drop TO cycles after digit3.
      drive(4'b1110, 8'h40, 20);
      drive(4'b1101, 8'h79, 20);
      drive(4'b1011, 8'h24, 20);
      drive(4'b0111, 8'h30, 20);
      drive(4'b1111, 8'hFF, 100);
      check_state("timeout");
      chk("timeout_delay", fall_edge - tick_edge, int'(TO));
      chk("timeout_led3_kept", 32'(bus.led3), 32'h30);

      // Reset right after the digit1 capture.
      drive(4'b1110, 8'h12, 20);
      drive(4'b1101, 8'h02, 20);
      bus.an_in   = 4'hF;
      bus.sseg_in = 8'hFF;
      reset       = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      repeat (3) @(negedge clk);
      model_reset();
      reset = 1'b1;
      drive(4'b1110, 8'h19, 20);
      drive(4'b1101, 8'h78, 20);
      drive(4'b1011, 8'h00, 20);
      drive(4'b0111, 8'h10, 20);
      check_state("post_reset");

      // Randomized scans, biased toward in-order digits.
      ld = 3;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 45) begin
            ld = (ld + 1) % 4;
            an = digit_an(ld);
         end else if (r < 70) begin
            ld = int'($urandom_range(0, 3));
            an = digit_an(ld);
         end else if (r < 85) begin
            an = 4'hF;
         end else begin
            an = 4'($urandom);
         end
         sg = 8'($urandom);
         if ({an, sg} == prev_val) sg = ~sg;
         n = int'($urandom_range(1, 12));
         drive(an, sg, n);
         if (n >= int'(S) + 3) check_state("rnd");
      end
      drive(4'b1111, 8'hFF, 200);
      check_state("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
